// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit, one radix-2 step per cycle
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   i_1/i_2  - operand 1 (multiplicand / dividend), operand 2 (multiplier / divisor)
//   ctrl     - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   i_start  - request, accepted in IDLE or DONE when i_flush is low
//   i_flush  - abort of any operation in progress
//   o_busy   - high while iterating
//   o_valid  - one-cycle pulse when o_1 holds a new result
//   o_1      - result, held until the next o_valid
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i_1,
    input  logic [XLEN-1:0] i_2,
    input  logic [2:0]      ctrl,
    input  logic            i_start,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_1
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;
    logic [4:0] cnt;
    logic [2:0] op;
    logic neg;
    // mul: hi = partial product, lo = multiplier being shifted out, b = multiplicand
    // div: hi = partial remainder, lo = dividend out / quotient in, b = divisor
    logic [XLEN-1:0] hi, lo, b;
    logic accept, last, s1, s2, n1, n2, div0, ovf, bypass;
    logic [XLEN-1:0] m1, m2, byp_res, nxt_hi, nxt_lo, res;
    logic [XLEN:0] sum, t, d;
    logic [2*XLEN-1:0] v, p;

    always_comb begin
        accept  = i_start && !i_flush && state != CALC;
        last    = state == CALC && cnt == 5'd31;
        s1      = ctrl[2] ? !ctrl[0] : ctrl[1] ^ ctrl[0];
        s2      = ctrl[2] ? !ctrl[0] : ctrl[1:0] == 2'b01;
        n1      = s1 && i_1[XLEN-1];
        n2      = s2 && i_2[XLEN-1];
        m1      = n1 ? -i_1 : i_1;
        m2      = n2 ? -i_2 : i_2;
        div0    = ctrl[2] && i_2 == '0;
        ovf     = ctrl[2] && !ctrl[0] && i_1 == {1'b1, {(XLEN-1){1'b0}}} && i_2 == '1;
        bypass  = div0 || ovf;
        byp_res = div0 ? (ctrl[1] ? i_1 : '1) : (ctrl[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        t       = {hi, lo[XLEN-1]};
        d       = t - {1'b0, b};
        // restoring division keeps the trial difference only when it did not borrow
        nxt_hi  = op[2] ? (d[XLEN] ? t[XLEN-1:0] : d[XLEN-1:0]) : sum[XLEN:1];
        nxt_lo  = op[2] ? {lo[XLEN-2:0], !d[XLEN]} : {sum[0], lo[XLEN-1:1]};
        // zero-extending the divide result lets one 2*XLEN negation serve both paths
        v       = op[2] ? {{XLEN{1'b0}}, op[1] ? nxt_hi : nxt_lo} : {nxt_hi, nxt_lo};
        p       = neg ? -v : v;
        res     = (op[2] || op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end

    always_comb begin
        o_busy    = state == CALC;
        o_valid   = state == DONE;
        state_nxt = i_flush ? IDLE :
                    accept ? (bypass ? DONE : CALC) :
                    state == DONE ? IDLE :
                    last ? DONE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            op  <= '0;
            neg <= 1'b0;
            hi  <= '0;
            lo  <= '0;
            b   <= '0;
            o_1 <= '0;
        end else if (accept) begin
            cnt <= '0;
            op  <= ctrl;
            // remainder follows the dividend sign; everything else the product of signs
            neg <= (ctrl[2] && ctrl[1]) ? n1 : n1 ^ n2;
            hi  <= '0;
            lo  <= ctrl[2] ? m1 : m2;
            b   <= ctrl[2] ? m2 : m1;
            if (bypass) o_1 <= byp_res;
        end else if (state == CALC) begin
            cnt <= cnt + 5'd1;
            hi  <= nxt_hi;
            lo  <= nxt_lo;
            if (last && !i_flush) o_1 <= res;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table, corner sequences and random ops against a reference model
module tb_muldiv_unit;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] i_1 = '0, i_2 = '0;
    logic [2:0] ctrl = '0;
    logic i_start = 1'b0, i_flush = 1'b0;
    logic o_busy, o_valid;
    logic [31:0] o_1;
    int checks = 0, failures = 0;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .i_1(i_1), .i_2(i_2), .ctrl(ctrl),
        .i_start(i_start), .i_flush(i_flush),
        .o_busy(o_busy), .o_valid(o_valid), .o_1(o_1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, pr;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (c)
            3'd1:    pr = sa * sb;
            3'd2:    pr = sa * ub;
            default: pr = ua * ub;
        endcase
        if (!c[2]) return c == 3'd0 ? pr[31:0] : pr[63:32];
        if (b == 0) return c[1] ? a : 32'hFFFFFFFF;
        if (!c[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return c[1] ? 32'd0 : 32'h80000000;
        case (c)
            3'd4:    return 32'(ia / ib);
            3'd5:    return a / b;
            3'd6:    return 32'(ia % ib);
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c[2] && (b == 0 || (!c[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    // present a request, scramble the inputs after acceptance, wait for o_valid
    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy_seen);
        ctrl = c; i_1 = a; i_2 = b; i_start = 1'b1;
        tick;
        i_start = 1'b0; i_1 = $urandom; i_2 = $urandom; ctrl = 3'($urandom);
        lat = 1;
        busy_seen = o_busy;
        while (!o_valid && lat < 40) begin
            tick;
            lat++;
            busy_seen |= o_busy;
        end
        res = o_1;
    endtask

    initial begin
        logic [31:0] res, prev;
        logic busy_seen;
        int lat, n;

        tbl.push_back('{3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33});
        tbl.push_back('{3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33});
        tbl.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        tbl.push_back('{3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33});
        tbl.push_back('{3'd2, 32'd2, 32'hFFFFFFFF, 32'd1, 33});
        tbl.push_back('{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33});
        tbl.push_back('{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33});
        tbl.push_back('{3'd5, 32'hFFFFFFFE, 32'd2, 32'h7FFFFFFF, 33});
        tbl.push_back('{3'd7, 32'hFFFFFFF9, 32'd2, 32'd1, 33});
        tbl.push_back('{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33});
        tbl.push_back('{3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1});
        tbl.push_back('{3'd6, 32'd5, 32'd0, 32'd5, 1});
        tbl.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        tbl.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1});
        tbl.push_back('{3'd5, 32'd9, 32'd0, 32'hFFFFFFFF, 1});
        tbl.push_back('{3'd7, 32'd7, 32'd0, 32'd7, 1});

        #12;
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_o1", o_1, 32'd0);
        #10 rst_n = 1'b1;

        foreach (tbl[i]) begin
            issue(tbl[i].c, tbl[i].a, tbl[i].b, res, lat, busy_seen);
            chk($sformatf("tbl%0d_res", i), res, tbl[i].exp);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_busy", i), {31'd0, busy_seen}, {31'd0, tbl[i].lat == 33});
            tick;
            chk($sformatf("tbl%0d_pulse", i), {31'd0, o_valid}, 32'd0);
        end

        // a start while iterating is ignored
        ctrl = 3'd0; i_1 = 32'd6; i_2 = 32'd7; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        n = 1;
        repeat (4) begin tick; n++; end
        ctrl = 3'd3; i_1 = 32'd100; i_2 = 32'd100; i_start = 1'b1;
        tick; n++;
        i_start = 1'b0;
        while (!o_valid && n < 40) begin tick; n++; end
        chk("ignore_lat", n, 33);
        chk("ignore_res", o_1, 32'd42);
        tick;

        // flush mid-iteration, then a new start right after
        ctrl = 3'd0; i_1 = 32'd9; i_2 = 32'd9; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        repeat (9) tick;
        i_flush = 1'b1;
        tick;
        i_flush = 1'b0;
        chk("flush_busy", {31'd0, o_busy}, 32'd0);
        chk("flush_valid", {31'd0, o_valid}, 32'd0);
        chk("flush_o1", o_1, 32'd42);
        issue(3'd0, 32'd11, 32'd13, res, lat, busy_seen);
        chk("after_flush_lat", lat, 33);
        chk("after_flush_res", res, 32'd143);
        tick;

        // flush and start together while iterating: flush wins, start dropped
        ctrl = 3'd0; i_1 = 32'd5; i_2 = 32'd5; i_start = 1'b1;
        tick;
        tick;
        i_flush = 1'b1; i_start = 1'b1; i_1 = 32'd3;
        tick;
        i_flush = 1'b0; i_start = 1'b0;
        chk("flush_start_busy", {31'd0, o_busy}, 32'd0);
        n = 0;
        repeat (40) begin tick; n += int'(o_valid); end
        chk("flush_start_novalid", n, 0);
        chk("flush_start_o1", o_1, 32'd143);

        // flush in the final iteration cycle must not publish a result
        ctrl = 3'd0; i_1 = 32'd2; i_2 = 32'd3; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        repeat (31) tick;
        chk("last_calc_busy", {31'd0, o_busy}, 32'd1);
        i_flush = 1'b1;
        tick;
        i_flush = 1'b0;
        chk("last_flush_valid", {31'd0, o_valid}, 32'd0);
        chk("last_flush_o1", o_1, 32'd143);

        // flush with start in DONE, and in IDLE
        issue(3'd3, 32'd4, 32'd4, res, lat, busy_seen);
        chk("done_flush_pre", res, 32'd0);
        i_flush = 1'b1; i_start = 1'b1;
        tick;
        chk("done_flush_valid", {31'd0, o_valid}, 32'd0);
        chk("done_flush_busy", {31'd0, o_busy}, 32'd0);
        tick;
        i_flush = 1'b0; i_start = 1'b0;
        chk("idle_flush_busy", {31'd0, o_busy}, 32'd0);

        // back-to-back: start accepted in the DONE cycle
        issue(3'd0, 32'd20, 32'd30, res, lat, busy_seen);
        chk("b2b_first", res, 32'd600);
        issue(3'd4, 32'd100, 32'hFFFFFFF9, res, lat, busy_seen);
        chk("b2b_lat", lat, 33);
        chk("b2b_res", res, 32'hFFFFFFF2);
        tick;

        for (int i = 0; i < 150; i++) begin
            logic [2:0] c;
            logic [31:0] a, b;
            c = 3'($urandom);
            a = pick();
            b = pick();
            issue(c, a, b, res, lat, busy_seen);
            chk($sformatf("rnd%0d_c%0d_%h_%h", i, c, a, b), res, model(c, a, b));
            chk($sformatf("rnd%0d_lat", i), lat, model_lat(c, a, b));
            if ($urandom % 2 == 0) tick;
        end
        tick;

        // asynchronous reset mid-iteration
        issue(3'd0, 32'd3, 32'd5, res, lat, busy_seen);
        prev = res;
        chk("pre_reset_o1", prev, 32'd15);
        tick;
        ctrl = 3'd0; i_1 = 32'd8; i_2 = 32'd8; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        repeat (14) tick;
        rst_n = 1'b0;
        #1;
        chk("areset_busy", {31'd0, o_busy}, 32'd0);
        chk("areset_valid", {31'd0, o_valid}, 32'd0);
        chk("areset_o1", o_1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin tick; n += int'(o_valid); end
        chk("areset_novalid", n, 0);

        // first edge with reset released accepts a start
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd1, 32'h80000000, 32'h80000000, res, lat, busy_seen);
        chk("first_start_lat", lat, 33);
        chk("first_start_res", res, 32'h40000000);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_1  input  32  signed operand 1 (multiplicand / dividend).
REQ-005 Port: i_2  input  32  signed operand 2 (multiplier / divisor).
REQ-006 Port: ctrl  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: i_start  input  1  request; operands and ctrl sampled on the edge where it is accepted.
REQ-008 Port: i_flush  input  1  synchronous abort of any operation in progress.
REQ-009 Port: o_busy  output  1  high while in state CALC.
REQ-010 Port: o_valid  output  1  one-cycle pulse, o_1 holds a new result.
REQ-011 Port: o_1  output  32  result; holds its last value until the next o_valid.

Function
REQ-012 FSM states IDLE, CALC, DONE; o_busy = (state==CALC); o_valid = (state==DONE).
REQ-013 i_start accepted only in IDLE or DONE with i_flush low; i_start in CALC is ignored, with no queueing.
REQ-014 Accept in IDLE/DONE: operands, ctrl latched; next state CALC, with iteration counter loaded to 0.
REQ-015 CALC: one radix-2 step per cycle; exactly 32 CALC cycles; after the 32nd, next state DONE.
REQ-016 Normal latency: start accepted at edge T0 -> o_valid high during cycle after edge T33 (33 edges).
REQ-017 DONE lasts one cycle, then IDLE unless a new start is accepted in DONE (back-to-back, next state CALC).
REQ-018 MUL: low 32 bits of the 64-bit product; MULH/MULHSU/MULHU: high 32 bits, with operands signed*signed, signed*unsigned, unsigned*unsigned respectively.
REQ-019 Signed multiply: magnitudes are multiplied unsigned; the 64-bit result is negated when the sign flag is set; results are exact in two's complement.
REQ-020 DIV/REM: quotient truncates toward zero; remainder takes the sign of the dividend; DIVU/REMU unsigned.
REQ-021 Divide by zero (i_2==0): quotient = 32'hFFFFFFFF, remainder = i_1, for both signed and unsigned ops.
REQ-022 Signed overflow (i_1==32'h80000000, i_2==32'hFFFFFFFF, DIV/REM): quotient = 32'h80000000, remainder = 0.
REQ-023 REQ-021/022 cases bypass CALC: accept at T0 -> DONE at T1; o_busy never asserted.
REQ-024 i_flush high in CALC or DONE: next state IDLE, no o_valid, and o_1 is unchanged.
REQ-025 i_flush and i_start high together: flush wins and the start is dropped.
REQ-026 Changes to i_1/i_2/ctrl after acceptance have no effect on the operation in flight.
REQ-027 o_1 updates only on the edge entering DONE.

Reset
REQ-028 rst_n low: immediately state IDLE, o_busy=0, o_valid=0, o_1=0, counter=0, and internal accumulators cleared.
REQ-029 Reset mid-CALC aborts the operation; no o_valid follows reset deassertion.
REQ-030 First start is accepted on the first rising edge with rst_n high.

Verification
REQ-031 MUL 7 * -3 -> o_valid at T33, o_1=32'hFFFFFFEB; MULH same operands -> 32'hFFFFFFFF.
REQ-032 MULHU 32'hFFFFFFFF * 32'hFFFFFFFF -> o_1=32'hFFFFFFFE; MULHSU -1 * 2 -> 32'hFFFFFFFF.
REQ-033 DIV -7 / 2 -> o_1=-3; REM -7 / 2 -> o_1=-1; DIVU 32'hFFFFFFFE / 2 -> 32'h7FFFFFFF.
REQ-034 DIV 5 / 0 -> o_valid at T1, o_1=32'hFFFFFFFF; REM 5 / 0 -> o_1=5; DIV 32'h80000000 / -1 -> o_1=32'h80000000 at T1.
REQ-035 Start, then i_start again at T5 (ignored), then i_flush at T10 -> IDLE at T11, no o_valid, o_1 unchanged; a new start at T11 completes at T44.
REQ-036 rst_n low at T15 of CALC -> outputs 0 asynchronously; back-to-back start in DONE cycle -> second o_valid exactly 33 edges after first.
